// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the 5-stage RISC-V core.
// This block holds the EX-stage branch/jump resolver, the EX operand
// forwarding selectors, the ID-stage load-use hazard detector and a sticky
// halt flag. Everything except halted is combinational, so each output
// reacts to its inputs in the same cycle.
module pipe_ctrl_unit #(
    parameter int PC_W      = 9,
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_W-1:0]      ex_pc,
    input  logic [DATA_W-1:0]    ex_imm,
    input  logic                 ex_branch,
    input  logic                 ex_jump,
    input  logic                 ex_jalr,
    input  logic                 ex_halt,
    input  logic [DATA_W-1:0]    ex_rs1_data,
    input  logic [DATA_W-1:0]    ex_alu_result,
    input  logic [RF_ADDR_W-1:0] ex_rs1,
    input  logic [RF_ADDR_W-1:0] ex_rs2,
    input  logic [RF_ADDR_W-1:0] mem_rd,
    input  logic [RF_ADDR_W-1:0] wb_rd,
    input  logic                 mem_regwrite,
    input  logic                 wb_regwrite,
    input  logic [RF_ADDR_W-1:0] id_rs1,
    input  logic [RF_ADDR_W-1:0] id_rs2,
    input  logic [RF_ADDR_W-1:0] ex_rd,
    input  logic                 ex_memread,
    output logic [DATA_W-1:0]    br_imm,
    output logic [DATA_W-1:0]    pc_four,
    output logic [DATA_W-1:0]    br_pc,
    output logic                 pc_sel,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 stall,
    output logic                 halted
);

    // The PC is narrower than the datapath, so it is zero-extended before
    // any address arithmetic.
    logic [DATA_W-1:0] pc_full;
    logic [DATA_W-1:0] jalr_sum;
    logic [DATA_W-1:0] jalr_target;

    // Only bit 0 of the ALU result carries the branch condition.
    logic unused_alu_bits;
    assign unused_alu_bits = ^ex_alu_result[DATA_W-1:1];

    assign pc_full     = {{(DATA_W-PC_W){1'b0}}, ex_pc};
    assign jalr_sum    = ex_rs1_data + ex_imm;
    assign jalr_target = {jalr_sum[DATA_W-1:1], 1'b0};

    // Sequential-address and branch-target adders wrap modulo 2^DATA_W.
    always_comb begin
        br_imm  = pc_full + ex_imm;
        pc_four = pc_full + DATA_W'(4);
    end

    // Redirect selection: halt (current or sticky) blocks all redirects,
    // then jumps, then taken conditional branches.
    always_comb begin
        pc_sel = 1'b0;
        br_pc  = '0;
        if (ex_halt || halted) begin
            pc_sel = 1'b0;
            br_pc  = '0;
        end else if (ex_jump && ex_jalr) begin
            pc_sel = 1'b1;
            br_pc  = jalr_target;
        end else if (ex_jump) begin
            pc_sel = 1'b1;
            br_pc  = br_imm;
        end else if (ex_branch && ex_alu_result[0]) begin
            pc_sel = 1'b1;
            br_pc  = br_imm;
        end
    end

    // Operand A forwarding: the younger EX/MEM result wins over MEM/WB,
    // and x0 is never forwarded because its value is hardwired.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
            fwd_a = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
            fwd_a = 2'b01;
        end
    end

    // Operand B forwarding, same priority rule as operand A.
    always_comb begin
        fwd_b = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
            fwd_b = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
            fwd_b = 2'b01;
        end
    end

    // Load-use hazard: a load in EX whose destination feeds the ID
    // instruction needs one bubble. Flush priority is left to the datapath.
    always_comb begin
        stall = ex_memread && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

    // Sticky halt flag: set by a halt in EX, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (ex_halt) begin
            halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed steps followed by
// randomized stimulus compared against a behavioural reference model.
module tb_pipe_ctrl_unit;

  localparam int PC_W      = 9;
  localparam int DATA_W    = 32;
  localparam int RF_ADDR_W = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [PC_W-1:0]      ex_pc;
  logic [DATA_W-1:0]    ex_imm;
  logic                 ex_branch;
  logic                 ex_jump;
  logic                 ex_jalr;
  logic                 ex_halt;
  logic [DATA_W-1:0]    ex_rs1_data;
  logic [DATA_W-1:0]    ex_alu_result;
  logic [RF_ADDR_W-1:0] ex_rs1;
  logic [RF_ADDR_W-1:0] ex_rs2;
  logic [RF_ADDR_W-1:0] mem_rd;
  logic [RF_ADDR_W-1:0] wb_rd;
  logic                 mem_regwrite;
  logic                 wb_regwrite;
  logic [RF_ADDR_W-1:0] id_rs1;
  logic [RF_ADDR_W-1:0] id_rs2;
  logic [RF_ADDR_W-1:0] ex_rd;
  logic                 ex_memread;
  logic [DATA_W-1:0]    br_imm;
  logic [DATA_W-1:0]    pc_four;
  logic [DATA_W-1:0]    br_pc;
  logic                 pc_sel;
  logic [1:0]           fwd_a;
  logic [1:0]           fwd_b;
  logic                 stall;
  logic                 halted;

  int errors = 0;
  int checks = 0;
  bit model_halted;

  pipe_ctrl_unit #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_halt(ex_halt), .ex_rs1_data(ex_rs1_data),
    .ex_alu_result(ex_alu_result),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .br_imm(br_imm), .pc_four(pc_four), .br_pc(br_pc),
    .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .halted(halted)
  );

  // Clock
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ex_pc = '0; ex_imm = '0; ex_branch = 0; ex_jump = 0; ex_jalr = 0;
    ex_halt = 0; ex_rs1_data = '0; ex_alu_result = '0;
    ex_rs1 = '0; ex_rs2 = '0; mem_rd = '0; wb_rd = '0;
    mem_regwrite = 0; wb_regwrite = 0; id_rs1 = '0; id_rs2 = '0;
    ex_rd = '0; ex_memread = 0;
  endtask

  // Reference: forward source for one operand register
  function automatic logic [1:0] ref_fwd(input int rs);
    if (rs == 0) return 2'd0;
    if (mem_regwrite && int'(mem_rd) == rs) return 2'd2;
    if (wb_regwrite && int'(wb_rd) == rs) return 2'd1;
    return 2'd0;
  endfunction

  // Compare every output against the reference model for the current inputs
  task automatic check_model(input string tag);
    longint unsigned pcv, bimm, p4, tgt;
    bit sel;
    bit stl;
    pcv  = longint'(ex_pc);
    bimm = (pcv + longint'(ex_imm)) % 64'h1_0000_0000;
    p4   = (pcv + 4) % 64'h1_0000_0000;
    sel  = 0;
    tgt  = 0;
    if (ex_halt || model_halted) begin
      sel = 0; tgt = 0;
    end else if (ex_jump && ex_jalr) begin
      sel = 1;
      tgt = (longint'(ex_rs1_data) + longint'(ex_imm)) % 64'h1_0000_0000;
      tgt = tgt - (tgt % 2);
    end else if (ex_jump || (ex_branch && ex_alu_result[0])) begin
      sel = 1; tgt = bimm;
    end
    stl = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    chk({tag, ".br_imm"},  br_imm,  bimm[31:0]);
    chk({tag, ".pc_four"}, pc_four, p4[31:0]);
    chk({tag, ".pc_sel"},  32'(pc_sel), 32'(sel));
    chk({tag, ".br_pc"},   br_pc,   tgt[31:0]);
    chk({tag, ".fwd_a"},   32'(fwd_a), 32'(ref_fwd(int'(ex_rs1))));
    chk({tag, ".fwd_b"},   32'(fwd_b), 32'(ref_fwd(int'(ex_rs2))));
    chk({tag, ".stall"},   32'(stall), 32'(stl));
    chk({tag, ".halted"},  32'(halted), 32'(model_halted));
  endtask

  initial begin
    // Reset phase
    clear_inputs();
    model_halted = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 chk("reset.halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 0;

    // Branch taken / not taken
    clear_inputs();
    ex_pc = 9'h010; ex_imm = 32'hFFFF_FFF8; ex_branch = 1; ex_alu_result = 32'd1;
    #1;
    chk("br.br_imm", br_imm, 32'h008);
    chk("br.pc_four", pc_four, 32'h014);
    chk("br.pc_sel", 32'(pc_sel), 32'd1);
    chk("br.br_pc", br_pc, 32'h008);
    ex_alu_result = 32'd0;
    #1;
    chk("br_nt.pc_sel", 32'(pc_sel), 32'd0);
    chk("br_nt.br_pc", br_pc, 32'd0);

    // JALR then JAL, jump over a taken branch
    clear_inputs();
    ex_jump = 1; ex_jalr = 1; ex_rs1_data = 32'h101; ex_imm = 32'd4;
    #1;
    chk("jalr.br_pc", br_pc, 32'h104);
    chk("jalr.pc_sel", 32'(pc_sel), 32'd1);
    ex_jalr = 0; ex_pc = 9'h020; ex_imm = 32'h40;
    ex_branch = 1; ex_alu_result = 32'd1;
    #1;
    chk("jal.br_pc", br_pc, 32'h060);
    chk("jal.pc_sel", 32'(pc_sel), 32'd1);

    // Forwarding priority and x0
    clear_inputs();
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1;
    #1 chk("fwd.mem_wins", 32'(fwd_a), 32'd2);
    mem_regwrite = 0;
    #1 chk("fwd.wb", 32'(fwd_a), 32'd1);
    mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
    #1 chk("fwd.x0", 32'(fwd_a), 32'd0);
    ex_rs2 = 7; wb_rd = 7; wb_regwrite = 1;
    #1 chk("fwd.b_wb", 32'(fwd_b), 32'd1);

    // Load-use hazard
    clear_inputs();
    ex_memread = 1; ex_rd = 3; id_rs2 = 3;
    #1 chk("stall.hit", 32'(stall), 32'd1);
    ex_rd = 0; id_rs1 = 0;
    #1 chk("stall.x0", 32'(stall), 32'd0);
    ex_rd = 3; ex_memread = 0;
    #1 chk("stall.noload", 32'(stall), 32'd0);

    // Halt dominance, sticky halt, async reset
    @(negedge clk);
    clear_inputs();
    ex_halt = 1; ex_jump = 1; ex_pc = 9'h030; ex_imm = 32'h10;
    #1;
    chk("halt.pc_sel", 32'(pc_sel), 32'd0);
    chk("halt.br_pc", br_pc, 32'd0);
    @(posedge clk);
    #1 chk("halt.set", 32'(halted), 32'd1);
    @(negedge clk);
    ex_halt = 0; ex_jump = 0; ex_branch = 1; ex_alu_result = 32'd1;
    ex_memread = 1; ex_rd = 4; id_rs1 = 4;
    #1;
    chk("halted.pc_sel", 32'(pc_sel), 32'd0);
    chk("halted.stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1 chk("halted.sticky", 32'(halted), 32'd1);
    #2 reset = 1;
    #1;
    chk("areset.halted", 32'(halted), 32'd0);
    chk("areset.pc_sel", 32'(pc_sel), 32'd1);
    chk("areset.br_pc", br_pc, 32'h040);
    reset = 0;
    model_halted = 0;

    // Randomized phase against the reference model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ex_pc = 9'($urandom_range(0, 511));
      ex_imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)));
      ex_branch = 1'($urandom_range(0, 1));
      ex_jump = ($urandom_range(0, 3) == 0);
      ex_jalr = 1'($urandom_range(0, 1));
      ex_halt = ($urandom_range(0, 19) == 0);
      ex_rs1_data = $urandom;
      ex_alu_result = $urandom;
      ex_rs1 = 5'($urandom_range(0, 3));
      ex_rs2 = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1));
      wb_regwrite = 1'($urandom_range(0, 1));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      ex_memread = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) begin
        reset = 1;
        model_halted = 0;
        #1 chk("rnd.areset", 32'(halted), 32'd0);
        reset = 0;
      end
      #1 check_model("rnd");
      @(posedge clk);
      if (ex_halt) model_halted = 1;
      #1 chk("rnd.halted_edge", 32'(halted), 32'(model_halted));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Combined pipeline-control block for the 5-stage RISC-V core.
- Contains the EX-stage branch/jump resolver, the EX-stage operand forwarding selector and the ID-stage load-use hazard detector.
- Adds a sticky halt register.
- Outputs feed the PC mux, the IF/ID and ID/EX flush/stall logic and the EX operand muxes.

Parameters:
- PC_W, 9, program counter width.
- DATA_W, 32, datapath width.
- RF_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ex_pc  in  PC_W  PC of the instruction in EX.
- ex_imm  in  DATA_W  sign-extended immediate of the EX instruction.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_jump  in  1  EX instruction is JAL/JALR.
- ex_jalr  in  1  with ex_jump: target is register-relative (JALR).
- ex_halt  in  1  EX instruction is a halt.
- ex_rs1_data  in  DATA_W  rs1 value (JALR base).
- ex_alu_result  in  DATA_W  ALU result; bit 0 is the branch-taken condition.
- ex_rs1, ex_rs2  in  RF_ADDR_W  EX source registers.
- mem_rd, wb_rd  in  RF_ADDR_W  destinations in EX/MEM and MEM/WB.
- mem_regwrite, wb_regwrite  in  1  write enables of EX/MEM and MEM/WB.
- id_rs1, id_rs2  in  RF_ADDR_W  sources of the instruction in ID.
- ex_rd  in  RF_ADDR_W  destination of the EX instruction.
- ex_memread  in  1  EX instruction is a load.
- br_imm  out  DATA_W  PC+imm.
- pc_four  out  DATA_W  PC+4.
- br_pc  out  DATA_W  redirect target.
- pc_sel  out  1  redirect PC / flush IF/ID and ID/EX.
- fwd_a, fwd_b  out  2  operand forward selects.
- stall  out  1  freeze PC and IF/ID; insert bubble in ID/EX.
- halted  out  1  sticky halt status.

Behaviour:
- All outputs except halted are purely combinational; zero latency.

Branch unit:
- pc_full = zero-extend(ex_pc) to DATA_W.
- br_imm = pc_full + ex_imm, modulo 2^DATA_W.
- pc_four = pc_full + 4, modulo 2^DATA_W.
- Target priority, highest first:
  - (ex_halt or halted): pc_sel=0, br_pc=0.
  - ex_jump and ex_jalr: pc_sel=1, br_pc=(ex_rs1_data+ex_imm) with bit 0 cleared.
  - ex_jump: pc_sel=1, br_pc=br_imm.
  - ex_branch and ex_alu_result[0]=1: pc_sel=1, br_pc=br_imm.
  - else: pc_sel=0, br_pc=0.
- Only br_pc[PC_W-1:0] is used by the PC; upper bits are still computed.

Forwarding unit (same rule for fwd_a/ex_rs1 and fwd_b/ex_rs2):
- 2'b10 if mem_regwrite, mem_rd!=0 and mem_rd==rs.
- Else 2'b01 if wb_regwrite, wb_rd!=0 and wb_rd==rs.
- Else 2'b00.
- EX/MEM wins when both stages match.
- 2'b11 is never produced.

Hazard detection:
- stall = ex_memread and ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2).
- stall is independent of pc_sel; the datapath gives flush priority.

Halt register:
- halted is set at the rising clk edge when ex_halt=1.
- Stays 1 until reset; reset (asynchronous) forces halted=0 immediately.
- While halted=1: pc_sel=0, br_pc=0; stall and forwarding still operate.

Reset:
- Only halted is stateful.
- Combinational outputs follow their inputs during reset.

Simultaneous events:
- halt dominates jump and branch.
- jump dominates branch.
- Any rs==0 never forwards.
- Load to x0 never stalls.

Test Plan:
1. ex_pc=0x010, ex_imm=0xFFFFFFF8, ex_branch=1, ex_alu_result=1 -> br_imm=0x008, pc_four=0x014, pc_sel=1, br_pc=0x008; same stimulus with ex_alu_result=0 -> pc_sel=0, br_pc=0.
2. ex_jump=1, ex_jalr=1, ex_rs1_data=0x101, ex_imm=4 -> br_pc=0x104, pc_sel=1; ex_jalr=0, ex_pc=0x020, ex_imm=0x40 -> br_pc=0x060, pc_sel=1.
3. ex_rs1=5, mem_rd=5, mem_regwrite=1, wb_rd=5, wb_regwrite=1 -> fwd_a=10; drop mem_regwrite -> fwd_a=01; set all rd=0 and ex_rs1=0 -> fwd_a=00; ex_rs2=7, wb_rd=7, wb_regwrite=1 -> fwd_b=01.
4. ex_memread=1, ex_rd=3, id_rs2=3 -> stall=1; ex_rd=0 with id_rs1=0 -> stall=0; ex_memread=0 -> stall=0.
5. ex_halt=1 with ex_jump=1 -> pc_sel=0; clock edge -> halted=1; drop ex_halt, assert a taken branch -> pc_sel=0; assert reset between edges -> halted=0 immediately, and the taken branch gives pc_sel=1.
